// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle for instr_fetch.
//   im_addr / im_rd                 : synchronous instruction ROM port
//   out_valid / out_ready           : handshake toward decode
//   out_instr / out_pc              : head instruction and its byte PC
//   redirect_valid / redirect_pc    : PC redirect from branch/jump resolution
// master = the fetch unit, slave = its environment (ROM, decode, branch unit).
interface instr_fetch_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_rd;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  modport master (
    output im_addr, out_valid, out_instr, out_pc,
    input  im_rd, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  im_addr, out_valid, out_instr, out_pc,
    output im_rd, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front-end.
// Drives the synchronous ROM word address from pc_q, tracks the one-cycle
// read latency with inflight_q/inflight_pc_q, and holds returned words in a
// 2-entry {pc, instr} FIFO whose head is presented to decode.
// Ports:
//   clk  - core clock (posedge)
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_if.master (ROM port, decode handshake, redirect)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [1:0]  occ;
  logic [31:0] ent0_pc, ent0_instr;
  logic [31:0] ent1_pc, ent1_instr;

  logic        pop;
  logic        issue;
  logic [2:0]  fill;
  logic [1:0]  slot;
  logic [31:0] redir_tgt;

  // ROM reads every cycle at pc_q; issue only decides whether that read
  // is kept.
  assign bus.im_addr   = pc_q[ADDR_W+1:2];
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_instr = ent0_instr;
  assign bus.out_pc    = ent0_pc;

  always_comb begin
    redir_tgt = bus.redirect_pc & ~32'h0000_0003;
    pop       = (occ != 2'd0) && bus.out_ready;
    // Entries committed after this edge, counting the word still in flight;
    // issuing only while this is <= 1 guarantees every returning word a slot.
    fill      = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight_q};
    issue     = (fill <= 3'd1);
    // Slot the in-flight word lands in once the head pop is applied.
    slot      = occ - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      occ           <= 2'd0;
      ent0_pc       <= 32'h0;
      ent0_instr    <= 32'h0;
      ent1_pc       <= 32'h0;
      ent1_instr    <= 32'h0;
    end else if (bus.redirect_valid) begin
      // Redirect drops both the buffered words and the pending ROM read.
      pc_q       <= redir_tgt;
      inflight_q <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end else begin
        inflight_q <= 1'b0;
      end

      occ <= occ - {1'b0, pop} + {1'b0, inflight_q};

      if (pop) begin
        ent0_pc    <= ent1_pc;
        ent0_instr <= ent1_instr;
      end
      // Later assignment wins, so a push into slot 0 overrides the shift.
      if (inflight_q) begin
        if (slot == 2'd0) begin
          ent0_pc    <= inflight_pc_q;
          ent0_instr <= bus.im_rd;
        end else begin
          ent1_pc    <= inflight_pc_q;
          ent1_instr <= bus.im_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;
  logic [31:0] exp_pc;
  int   npops = 0;

  instr_fetch_if #(.ADDR_W(6)) bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word i holds 0x1000_0000 + i.
  always @(posedge clk) bus.im_rd <= 32'h1000_0000 + {26'd0, bus.im_addr};

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {26'd0, pc[7:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs, check any accepted instruction against the
  // model's next-expected PC, advance the model, then return at the negedge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    if (bus.out_valid && rdy) begin
      chk("pop_pc", bus.out_pc, exp_pc);
      chk("pop_instr", bus.out_instr, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      npops++;
    end
    if (rv) exp_pc = rpc & ~32'h3;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        pv, phold;
    logic [31:0] ppc, pins;
    logic        r_rdy, r_rv;
    logic [31:0] r_pc;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    exp_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_addr", {26'd0, bus.im_addr}, 32'd0);
    rst = 1'b0;

    // Free run: valid after the second edge, then one per cycle.
    chk("lat_e0", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("lat_e1", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("lat_e2", {31'd0, bus.out_valid}, 32'd1);
    chk("first_pc", bus.out_pc, 32'h0);
    chk("first_instr", bus.out_instr, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h0);
    chk("nogap_valid", {31'd0, bus.out_valid}, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk("head_8", bus.out_pc, 32'h8);

    // Backpressure: head holds at 0x8, fetch stalls at 0x10.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_pc", bus.out_pc, 32'h8);
    end
    chk("bp_addr", {26'd0, bus.im_addr}, 32'd4);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("pre_redir_head", bus.out_pc, 32'h10);

    // Redirect flushes 0x10/0x14; target valid two edges later.
    step(1'b0, 1'b1, 32'h40);
    chk("redir_e0", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_e1", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_e2", {31'd0, bus.out_valid}, 32'd1);
    chk("redir_pc", bus.out_pc, 32'h40);
    chk("redir_instr", bus.out_instr, 32'h1000_0010);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect and word-address wrap.
    step(1'b1, 1'b1, 32'hFB);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_pc", bus.out_pc, 32'hF8);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc", bus.out_pc, 32'h100);
    chk("wrap_instr", bus.out_instr, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h0);

    // Redirect coincident with a pop of head 0x20.
    step(1'b1, 1'b1, 32'h20);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("co_head", bus.out_pc, 32'h20);
    step(1'b1, 1'b1, 32'h80);
    chk("co_e0", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("co_e1", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("co_e2", {31'd0, bus.out_valid}, 32'd1);
    chk("co_pc", bus.out_pc, 32'h80);
    step(1'b1, 1'b0, 32'h0);

    // Randomized traffic checked against the next-expected-PC model.
    npops = 0;
    for (int i = 0; i < 400; i++) begin
      r_rdy = ($urandom_range(3) != 0);
      r_rv  = ($urandom_range(19) == 0);
      r_pc  = $urandom;
      pv    = bus.out_valid;
      ppc   = bus.out_pc;
      pins  = bus.out_instr;
      phold = pv && !r_rdy && !r_rv;
      step(r_rdy, r_rv, r_pc);
      if (phold) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_pc", bus.out_pc, ppc);
        chk("hold_instr", bus.out_instr, pins);
      end
    end
    chk("rand_progress", {31'd0, (npops > 100)}, 32'd1);

    // Asynchronous reset between edges with the FIFO full.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_pc", bus.out_pc, 32'h0);
    chk("arst_addr", {26'd0, bus.im_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    chk("rel_e0", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rel_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rel_pc", bus.out_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch front-end that reads the synchronous instruction ROM: drives its word address, tracks the one-cycle read latency, and buffers the returned words.
- Delivers {pc, instr} to decode over a valid/ready handshake.
- Supports PC redirects from branch/jump resolution, which flush in-flight and buffered fetches.
- Sits between the PC logic and instruction memory on the fetch side of the rv32i core.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
- ADDR_W, 6, ROM word-address width (64 words).

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- im_addr  output  ADDR_W  ROM word address = pc_q[ADDR_W+1:2]; ROM registers data at posedge.
- im_rd  input  32  ROM read data, valid the cycle after the address was sampled.
- out_valid  output  1  buffered instruction available.
- out_ready  input  1  decode accepts head entry when out_valid && out_ready.
- out_instr  output  32  instruction at buffer head.
- out_pc  output  32  byte PC of out_instr.
- redirect_valid  input  1  load new PC, flush pipeline.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0.

Behaviour:
- Reset, asynchronous, all at once:
  - pc_q = RESET_PC, inflight_q = 0, occ = 0.
  - Buffer entries = 0, so out_valid = 0, out_instr = 0, out_pc = 0.
- Reset asserted mid-operation discards all buffered and in-flight data immediately.
- State:
  - pc_q: next PC to request.
  - inflight_q + inflight_pc_q: a read was issued at the previous edge.
  - 2-entry FIFO of {pc, instr}, with occ in 0..2.
- pop = out_valid && out_ready.
- issue = (occ - pop + inflight_q) <= 1.
  - This keeps data arriving from the ROM guaranteed a buffer slot.
  - im_addr always equals pc_q; the ROM reads every cycle, and issue only marks the read as wanted.
- On posedge with issue and no redirect:
  - inflight_q <= 1, inflight_pc_q <= pc_q, pc_q <= pc_q + 4.
  - Otherwise (no issue) inflight_q <= 0 and pc_q holds.
- On posedge with inflight_q = 1 and no redirect: push {inflight_pc_q, im_rd} into the FIFO.
- Push and pop in the same edge are both honoured, and occ is unchanged.
- Outputs out_valid/out_instr/out_pc come combinationally from the FIFO head: out_valid = (occ != 0).
- Latency: first posedge after reset release issues RESET_PC; out_valid rises after the second posedge. Steady state with out_ready=1 gives 1 instr/cycle.
- Backpressure (out_ready=0): FIFO fills to 2 and issue stops.
  - The final in-flight word is still captured.
  - No word is lost or duplicated.
  - out_instr/out_pc are held stable while out_valid && !out_ready.
- Redirect (priority over issue/push):
  - At posedge: pc_q <= {redirect_pc[31:2],2'b00}, inflight_q <= 0, FIFO flushed (occ <= 0).
  - A same-cycle pop counts as accepted by decode.
  - Next fetch issues the cycle after redirect; the first redirected instruction is valid 2 edges after the redirect edge.
  - Back-to-back redirects: the last one wins.
- PC arithmetic is 32-bit modulo 2^32.
  - im_addr wraps naturally: pc 0xFC -> 0x100 gives im_addr 63 -> 0.
  - out_pc keeps the full 32-bit value.
- No combinational path from im_rd to any output except via FIFO registers. out_ready affects only the issue decision, never im_addr.

Test Plan:
- Reset then free run: ROM model word i = 0x1000_0000+i, out_ready=1 -> out_valid after 2nd edge; sequence (pc,instr) = (0x0,0x10000000),(0x4,0x10000001),... one per cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles starting at pc 0x8 -> occ saturates at 2 and out_pc holds 0x8. On release, sequence resumes 0x8,0xC,0x10 with no loss or duplication.
- Redirect: redirect_valid with redirect_pc=0x40 while FIFO holds 0x10,0x14 -> those are never presented. Next valid output is (0x40,0x10000010) exactly 2 edges later, then 0x44.
- Misaligned redirect + wrap: redirect_pc=0xFB -> out_pc 0xF8, 0xFC, 0x100 with instr words 62, 63, 0 (im_addr wraps 63->0).
- Redirect coincident with pop at head 0x20 -> 0x20 counted as consumed once. Next output is the redirect target. No stale in-flight word appears.
- Async reset mid-stream (asserted between edges, with occ=2) -> out_valid drops immediately. After release, fetch restarts at RESET_PC.
